// File: rtl/safe_pkg.sv
// Shared types and constants for the safe controller input path.
package safe_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE         = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_HELD         = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_t;

  // Push-buttons on the board pull low when pressed.
  localparam logic KEY_PRESSED_LEVEL = 1'b0;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_REPEAT_DELAY    = 25000000;
  localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/safe_input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the input conditioner.
interface safe_input_conditioner_if #(
  parameter int N_KEYS = 2,
  parameter int N_SW   = 10
);

  logic [N_KEYS-1:0] key_n_raw;
  logic [N_SW-1:0]   sw_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_SW-1:0]   sw_stable;
  logic              sw_changed;

  modport master (
    input  key_n_raw,
    input  sw_raw,
    output key_level,
    output key_press,
    output key_release,
    output sw_stable,
    output sw_changed
  );

  modport slave (
    output key_n_raw,
    output sw_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  sw_stable,
    input  sw_changed
  );

endinterface

// File: rtl/debounce_cell.sv
// Two-flop synchroniser plus debounce counter for one asynchronous input bit.
module debounce_cell
  import safe_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic IDLE_VAL        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_r;
  logic             sync_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             differ_s;
  logic             done_s;

  assign differ_s = sync_r ^ stable_r;
  assign done_s   = differ_s & (cnt_r == CNT_LAST);

  // Synchronise, then accept a new value only after an unbroken run of DEBOUNCE_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r   <= IDLE_VAL;
      sync_r   <= IDLE_VAL;
      stable_r <= IDLE_VAL;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      if (!differ_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (done_s) begin
        stable_r <= sync_r;
        cnt_r    <= {CNT_W{1'b0}};
      end else if (cnt_r != CNT_LAST) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Strobes fire in the cycle before stable flips so consumers can register them alongside it.
  assign sync   = sync_r;
  assign stable = stable_r;
  assign rise   = done_s & ~stable_r;
  assign fall   = done_s &  stable_r;

endmodule

// File: rtl/safe_input_conditioner.sv
// Debounced keys (with press/release pulses) and switches for the safe controller.
// Define SAFE_AUTO_REPEAT_EN to build key auto-repeat while a key is held.
module safe_input_conditioner
  import safe_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                       clk,
  input  logic                       RESET,
  safe_input_conditioner_if.master   bus
);

  logic [N_KEYS-1:0] key_level_s;
  logic [N_KEYS-1:0] key_press_s;
  logic [N_KEYS-1:0] key_release_s;
  logic [N_SW-1:0]   sw_stable_s;
  logic [N_SW-1:0]   sw_rise_s;
  logic [N_SW-1:0]   sw_fall_s;
  logic [N_SW-1:0]   sw_sync_unused;
  logic              sw_changed_r;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic       sync_s;
    logic       stable_unused;
    logic       rise_s;
    logic       fall_s;
    logic       pressed_s;
    logic       press_done_s;
    logic       release_done_s;
    logic       rpt_fire_s;
    key_state_t state_r;
    logic       press_r;
    logic       release_r;
    logic       level_r;

    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_VAL        (~KEY_PRESSED_LEVEL)
    ) u_cell (
      .clk    (clk),
      .rst    (RESET),
      .din    (bus.key_n_raw[k]),
      .sync   (sync_s),
      .stable (stable_unused),
      .rise   (rise_s),
      .fall   (fall_s)
    );

    assign pressed_s      = (sync_s == KEY_PRESSED_LEVEL);
    assign press_done_s   = (KEY_PRESSED_LEVEL == 1'b0) ? fall_s : rise_s;
    assign release_done_s = (KEY_PRESSED_LEVEL == 1'b0) ? rise_s : fall_s;

`ifdef SAFE_AUTO_REPEAT_EN
    localparam int RPT_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    logic [RPT_W-1:0] rpt_cnt_r;

    assign rpt_fire_s = (state_r == KEY_HELD) && (rpt_cnt_r == RPT_W'(REPEAT_DELAY - 1));

    // Reload after each repeat so later pulses are REPEAT_PERIOD apart.
    always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
        rpt_cnt_r <= {RPT_W{1'b0}};
      end else if (state_r != KEY_HELD) begin
        rpt_cnt_r <= {RPT_W{1'b0}};
      end else if (rpt_fire_s) begin
        rpt_cnt_r <= RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        rpt_cnt_r <= rpt_cnt_r + RPT_W'(1);
      end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

    // Key FSM tracks the debounce cell so press/release pulses line up with its count.
    always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
        state_r   <= KEY_IDLE;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        level_r   <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        case (state_r)
          KEY_IDLE: begin
            if (pressed_s) state_r <= KEY_PRESS_WAIT;
          end
          KEY_PRESS_WAIT: begin
            if (!pressed_s) begin
              state_r <= KEY_IDLE;
            end else if (press_done_s) begin
              state_r <= KEY_HELD;
              press_r <= 1'b1;
              level_r <= 1'b1;
            end
          end
          KEY_HELD: begin
            if (!pressed_s) begin
              state_r <= KEY_RELEASE_WAIT;
            end else if (rpt_fire_s) begin
              press_r <= 1'b1;
            end
          end
          KEY_RELEASE_WAIT: begin
            if (pressed_s) begin
              state_r <= KEY_HELD;
            end else if (release_done_s) begin
              state_r   <= KEY_IDLE;
              release_r <= 1'b1;
              level_r   <= 1'b0;
            end
          end
          default: begin
            state_r <= KEY_IDLE;
            level_r <= 1'b0;
          end
        endcase
      end
    end

    assign key_level_s[k]   = level_r;
    assign key_press_s[k]   = press_r;
    assign key_release_s[k] = release_r;
  end

  for (genvar s = 0; s < N_SW; s++) begin : g_sw
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_VAL        (1'b0)
    ) u_cell (
      .clk    (clk),
      .rst    (RESET),
      .din    (bus.sw_raw[s]),
      .sync   (sw_sync_unused[s]),
      .stable (sw_stable_s[s]),
      .rise   (sw_rise_s[s]),
      .fall   (sw_fall_s[s])
    );
  end

  // One change pulse however many switches settle together.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sw_changed_r <= 1'b0;
    end else begin
      sw_changed_r <= |(sw_rise_s | sw_fall_s);
    end
  end

  assign bus.key_level   = key_level_s;
  assign bus.key_press   = key_press_s;
  assign bus.key_release = key_release_s;
  assign bus.sw_stable   = sw_stable_s;
  assign bus.sw_changed  = sw_changed_r;

endmodule

// File: tb/tb_safe_input_conditioner.sv
// Directed bench for safe_input_conditioner with DEBOUNCE_CYCLES=4 (6-cycle latency).
module tb_safe_input_conditioner;

  localparam int NK = 2;
  localparam int NS = 10;

  logic clk = 1'b0;
  logic RESET;

  always #5 clk = ~clk;

  safe_input_conditioner_if #(.N_KEYS(NK), .N_SW(NS)) bus ();

  safe_input_conditioner #(
    .N_KEYS          (NK),
    .N_SW            (NS),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Event log for key 1 and the switch change pulse, as cycle offsets since clear_mon.
  int p_q[$];
  int r_q[$];
  int c_q[$];
  int k0_cnt;
  int same_cnt;
  int bad_sw;
  int lvl_bad;
  int mon_off;
  logic [NS-1:0] sw_a;
  logic [NS-1:0] sw_b;

  task automatic clear_mon();
    p_q.delete();
    r_q.delete();
    c_q.delete();
    k0_cnt   = 0;
    same_cnt = 0;
    bad_sw   = 0;
    lvl_bad  = 0;
    mon_off  = 0;
  endtask

  task automatic watch(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.key_press[1])   p_q.push_back(mon_off + i);
      if (bus.key_release[1]) r_q.push_back(mon_off + i);
      if (bus.sw_changed)     c_q.push_back(mon_off + i);
      if (bus.key_press[0] || bus.key_release[0]) k0_cnt++;
      if ((bus.key_press & bus.key_release) != '0) same_cnt++;
      if (bus.sw_stable !== sw_a && bus.sw_stable !== sw_b) bad_sw++;
      if (bus.key_press[1] && !bus.key_level[1]) lvl_bad++;
      if (bus.key_release[1] && bus.key_level[1]) lvl_bad++;
    end
    mon_off += n;
  endtask

  function automatic bit q_eq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    RESET = 1'b1;
    bus.key_n_raw = 2'b11;
    bus.sw_raw = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.key_level !== 2'b00) begin errors++; $display("FAIL rst_level: got %b want 00", bus.key_level); end
    checks++; if (bus.key_press !== 2'b00) begin errors++; $display("FAIL rst_press: got %b want 00", bus.key_press); end
    checks++; if (bus.key_release !== 2'b00) begin errors++; $display("FAIL rst_release: got %b want 00", bus.key_release); end
    checks++; if (bus.sw_stable !== 10'h000) begin errors++; $display("FAIL rst_sw: got %h want 000", bus.sw_stable); end
    checks++; if (bus.sw_changed !== 1'b0) begin errors++; $display("FAIL rst_swchg: got %b want 0", bus.sw_changed); end
    RESET = 1'b0;
    sw_a = 10'h000; sw_b = 10'h000;
    clear_mon();
    watch(12);
    checks++; if (p_q.size() + r_q.size() + c_q.size() + k0_cnt != 0) begin
      errors++; $display("FAIL post_rst_pulses: got %0d pulses want 0", p_q.size() + r_q.size() + c_q.size() + k0_cnt); end
    checks++; if (bad_sw != 0 || bus.key_level !== 2'b00) begin
      errors++; $display("FAIL post_rst_levels: sw_bad=%0d level=%b want 0/00", bad_sw, bus.key_level); end
  endtask

  task automatic test_clean_press();
    int exp_q[$];
    sw_a = 10'h000; sw_b = 10'h000;
    clear_mon();
    bus.key_n_raw = 2'b01;
    watch(12);
    exp_q = {6};
    checks++; if (!q_eq(p_q, exp_q)) begin errors++; $display("FAIL press_time: got %p want %p", p_q, exp_q); end
    checks++; if (bus.key_level !== 2'b10 || lvl_bad != 0) begin
      errors++; $display("FAIL press_level: got %b (bad=%0d) want 10", bus.key_level, lvl_bad); end
    checks++; if (r_q.size() != 0 || k0_cnt != 0) begin
      errors++; $display("FAIL press_extra: release=%0d key0=%0d want 0", r_q.size(), k0_cnt); end
    clear_mon();
    bus.key_n_raw = 2'b11;
    watch(12);
    checks++; if (!q_eq(r_q, exp_q)) begin errors++; $display("FAIL release_time: got %p want %p", r_q, exp_q); end
    checks++; if (bus.key_level !== 2'b00 || p_q.size() != 0 || lvl_bad != 0) begin
      errors++; $display("FAIL release_level: level=%b press=%0d bad=%0d want 00/0/0", bus.key_level, p_q.size(), lvl_bad); end
  endtask

  task automatic test_bounce();
    int exp_q[$];
    sw_a = 10'h000; sw_b = 10'h000;
    clear_mon();
    bus.key_n_raw = 2'b01; watch(2);
    bus.key_n_raw = 2'b11; watch(2);
    bus.key_n_raw = 2'b01; watch(2);
    bus.key_n_raw = 2'b11; watch(2);
    checks++; if (p_q.size() != 0 || r_q.size() != 0) begin
      errors++; $display("FAIL bounce_quiet: press=%0d release=%0d want 0", p_q.size(), r_q.size()); end
    bus.key_n_raw = 2'b01; watch(12);
    exp_q = {14};
    checks++; if (!q_eq(p_q, exp_q)) begin errors++; $display("FAIL bounce_press: got %p want %p", p_q, exp_q); end
    clear_mon();
    bus.key_n_raw = 2'b11; watch(12);
    exp_q = {6};
    checks++; if (!q_eq(r_q, exp_q)) begin errors++; $display("FAIL bounce_release: got %p want %p", r_q, exp_q); end
  endtask

  task automatic test_switches();
    int exp_q[$];
    sw_a = 10'h000; sw_b = 10'h2A5;
    clear_mon();
    bus.sw_raw = 10'h201; watch(2);
    bus.sw_raw = 10'h000; watch(2);
    bus.sw_raw = 10'h2A5; watch(12);
    exp_q = {10};
    checks++; if (!q_eq(c_q, exp_q)) begin errors++; $display("FAIL sw_changed: got %p want %p", c_q, exp_q); end
    checks++; if (bus.sw_stable !== 10'h2A5) begin errors++; $display("FAIL sw_value: got %h want 2a5", bus.sw_stable); end
    checks++; if (bad_sw != 0) begin errors++; $display("FAIL sw_intermediate: got %0d odd cycles want 0", bad_sw); end
  endtask

  task automatic test_reset_mid_count();
    int exp_q[$];
    sw_a = 10'h000; sw_b = 10'h2A5;
    clear_mon();
    bus.key_n_raw = 2'b01;
    watch(3);
    RESET = 1'b1;
    #1;
    checks++; if (bus.key_level !== 2'b00 || bus.key_press !== 2'b00) begin
      errors++; $display("FAIL midrst_key: level=%b press=%b want 00/00", bus.key_level, bus.key_press); end
    checks++; if (bus.sw_stable !== 10'h000 || bus.sw_changed !== 1'b0) begin
      errors++; $display("FAIL midrst_sw: sw=%h chg=%b want 000/0", bus.sw_stable, bus.sw_changed); end
    checks++; if (p_q.size() != 0) begin errors++; $display("FAIL midrst_early: got %0d presses want 0", p_q.size()); end
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    clear_mon();
    watch(12);
    exp_q = {6};
    checks++; if (!q_eq(p_q, exp_q)) begin errors++; $display("FAIL midrst_press: got %p want %p", p_q, exp_q); end
    checks++; if (!q_eq(c_q, exp_q)) begin errors++; $display("FAIL midrst_swchg: got %p want %p", c_q, exp_q); end
    checks++; if (bus.sw_stable !== 10'h2A5 || bus.key_level !== 2'b10) begin
      errors++; $display("FAIL midrst_final: sw=%h level=%b want 2a5/10", bus.sw_stable, bus.key_level); end
  endtask

  task automatic test_repeat();
    int exp_p[$];
    int exp_r[$];
    sw_a = 10'h2A5; sw_b = 10'h2A5;
    bus.key_n_raw = 2'b11;
    repeat (12) @(negedge clk);
    clear_mon();
    bus.key_n_raw = 2'b01; watch(56);
    bus.key_n_raw = 2'b11; watch(20);
`ifdef SAFE_AUTO_REPEAT_EN
    exp_p = {6, 26, 34, 42, 50, 58};
`else
    exp_p = {6};
`endif
    exp_r = {62};
    checks++; if (!q_eq(p_q, exp_p)) begin errors++; $display("FAIL repeat_press: got %p want %p", p_q, exp_p); end
    checks++; if (!q_eq(r_q, exp_r)) begin errors++; $display("FAIL repeat_release: got %p want %p", r_q, exp_r); end
    checks++; if (same_cnt != 0 || k0_cnt != 0) begin
      errors++; $display("FAIL repeat_overlap: same=%0d key0=%0d want 0", same_cnt, k0_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_switches();
    test_reset_mid_count();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/safe_input_conditioner.md
# safe_input_conditioner

Input conditioning stage in front of the safe controller FSM. Synchronises, debounces and edge-detects the raw push-buttons and slide switches, then delivers clean levels and single-cycle press pulses. Its `key_press` output drives the FSM's ENTER input, and its `sw_stable` output feeds the password/attempt registers and the hint logic. No bounce or metastable value reaches the FSM.

## Interface
- `N_KEYS`, default 2: number of push-buttons.
- `N_SW`, default 10: number of slide switches.
- `DEBOUNCE_CYCLES`, default 500000: cycles an input must hold a new value before it is accepted (10 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY`, default 25000000: cycles a key is held before the first repeat pulse; used only with `SAFE_AUTO_REPEAT_EN`.
- `REPEAT_PERIOD`, default 5000000: cycles between later repeat pulses; used only with `SAFE_AUTO_REPEAT_EN`.
- `clk`, in, 1: system clock (MAX10_CLK1_50). Single clock domain.
- `RESET`, in, 1: asynchronous, active-high reset.
- `key_n_raw`, in, N_KEYS: raw buttons, active-low (0 = pressed), asynchronous.
- `sw_raw`, in, N_SW: raw switches, asynchronous.
- `key_level`, out, N_KEYS: debounced key state, active-high (1 = pressed).
- `key_press`, out, N_KEYS: one-cycle pulse on each accepted press, plus repeat pulses when the feature is enabled.
- `key_release`, out, N_KEYS: one-cycle pulse on each accepted release.
- `sw_stable`, out, N_SW: debounced switch values.
- `sw_changed`, out, 1: one-cycle pulse whenever any `sw_stable` bit changes.

## Operation
- Every input bit passes through its own 2-flop synchroniser and then its own independent debounce cell.
- **Debounce cell:** holds a stable value `s` and a counter.
  - If the synchronised input equals `s`, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while the input still differs, `s` flips, the counter clears, and a one-cycle `rise` or `fall` strobe is raised.
  - Any return to `s` before that point clears the counter. Partial counts are never kept.
- **Key FSM (per key):**
  - States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE → PRESS_WAIT when the synchronised input is pressed.
  - PRESS_WAIT → IDLE on a bounce back to released.
  - PRESS_WAIT → HELD when the count completes. This transition asserts `key_press` and sets `key_level`.
  - HELD → RELEASE_WAIT when the synchronised input is released.
  - RELEASE_WAIT → HELD on a bounce back to pressed.
  - RELEASE_WAIT → IDLE when the count completes. This transition asserts `key_release` and clears `key_level`.
- **Switches:** use the same debounce cell without the FSM. `sw_changed` is the registered OR of all switch strobes, so several switches settling in the same cycle give one pulse.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter saturates and never wraps.
- **Reset** (async assert, released synchronously by the system):
  - Synchroniser flops reset to the idle input value: keys 1 (released), switches 0.
  - `key_level`, `key_press`, `key_release`, `sw_stable` and `sw_changed` all reset to 0.
  - All counters reset to 0 and all FSMs to IDLE.
  - A reset during a count abandons it. A key held through reset is debounced again and gives a fresh `key_press`.
  - A switch that is 1 at reset release gives an `sw_stable` update and an `sw_changed` pulse after the normal latency.

## Timing
- All outputs are registered.
- Latency from a clean raw edge to the matching output change or pulse is 2 + `DEBOUNCE_CYCLES` cycles: 2 cycles of synchroniser plus the debounce count.
- Pulses are exactly one cycle wide.
- `key_press` and `key_release` for the same key can never occur in the same cycle.
- Consecutive press pulses for one key are at least 2·`DEBOUNCE_CYCLES` cycles apart.

## Configuration
- **`SAFE_AUTO_REPEAT_EN` defined:**
  - In HELD, a repeat counter runs.
  - The first extra `key_press` comes `REPEAT_DELAY` cycles after the initial press pulse.
  - Further pulses follow every `REPEAT_PERIOD` cycles while the key stays HELD.
  - Leaving HELD clears the repeat counter.
- **`SAFE_AUTO_REPEAT_EN` undefined:** no repeat logic is built, and exactly one `key_press` is produced per physical press.

## Structure
- Shared package `safe_pkg`:
  - key FSM state enum (`key_state_t`);
  - `KEY_PRESSED_LEVEL` = 1'b0;
  - `DEFAULT_DEBOUNCE_CYCLES`.
- Sub-module `debounce_cell`: synchroniser, counter and stable value, with `rise`/`fall` strobes.
  - Instantiated N_KEYS + N_SW times.
  - The key FSMs and repeat logic live in the top of this block.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and, when enabled, `REPEAT_DELAY`=20 and `REPEAT_PERIOD`=8.
- Reset with all keys released: `key_n_raw`=2'b11 and `sw_raw`=0 → all outputs 0 throughout, no pulses after reset release.
- Clean press: `key_n_raw[1]` 1→0 and held → `key_press[1]` high for exactly one cycle, 6 cycles after the edge, with `key_level[1]`=1 from that cycle on. Release → `key_release[1]` 6 cycles after the release edge.
- Bounce: `key_n_raw[1]` toggles 0,1,0,1 every 2 cycles, then stays 0 → no pulse during the bounces, and one `key_press` 6 cycles after the final edge.
- Switches: `sw_raw` 0→10'h2A5 with bits 0 and 9 glitching for 2 cycles → `sw_stable`=10'h2A5 and a single `sw_changed` pulse, with no intermediate `sw_stable` value.
- Reset mid-count: assert `RESET` 3 cycles after the press edge while the key stays held → outputs 0 immediately. After reset release, `key_press` follows 6 cycles later.
- With `SAFE_AUTO_REPEAT_EN`, key held for 50 cycles after the press pulse → extra `key_press` pulses at +20, +28, +36, +44 and +52 cycles only while HELD. Without the macro, exactly one pulse.
